// File: rtl/ysyx_2022040010_wb_retire.sv
// ysyx_2022040010_wb_retire: 2-entry in-order writeback/retire buffer with regfile bypass and halt draining.
module ysyx_2022040010_wb_retire #(
    parameter int XLEN = 64,
    parameter int AW   = 5,
    parameter int PCW  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PCW-1:0]  in_pc,
    input  logic            in_rf_we,
    input  logic [AW-1:0]   in_rf_waddr,
    input  logic [XLEN-1:0] in_rf_wdata,
    input  logic            in_halt,
    output logic            commit_valid,
    input  logic            commit_ready,
    output logic [PCW-1:0]  commit_pc,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic [AW-1:0]   q_addr,
    output logic            q_hit,
    output logic [XLEN-1:0] q_data,
    output logic [63:0]     retire_cnt,
    output logic            halted
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    state_t state;
    logic [PCW-1:0]  pc_m [2];
    logic            we_m [2];
    logic [AW-1:0]   wa_m [2];
    logic [XLEN-1:0] wd_m [2];
    logic            halt_m [2];
    logic            rd, wr, push, pop, hit0, hit1;
    logic [1:0]      count;
    assign in_ready     = count != 2'd2 && state == RUN;
    assign commit_valid = count != 2'd0 && state != HALTED;
    assign push         = in_valid && in_ready;
    assign pop          = commit_valid && commit_ready;
    assign halted       = state == HALTED;
    // Payload is never reset, so everything read from it is masked by occupancy.
    assign commit_pc = commit_valid ? pc_m[rd] : '0;
    assign rf_waddr  = count != 2'd0 ? wa_m[rd] : '0;
    assign rf_wdata  = count != 2'd0 ? wd_m[rd] : '0;
    assign rf_we     = pop && we_m[rd] && wa_m[rd] != '0;
    assign hit0      = count != 2'd0 && we_m[rd] && wa_m[rd] == q_addr;
    assign hit1      = count == 2'd2 && we_m[~rd] && wa_m[~rd] == q_addr;
    assign q_hit     = q_addr != '0 && (hit0 || hit1);
    assign q_data    = !q_hit ? '0 : hit1 ? wd_m[~rd] : wd_m[rd];
    always_ff @(posedge clk) begin
        if (push) begin
            pc_m[wr]   <= in_pc;
            we_m[wr]   <= in_rf_we;
            wa_m[wr]   <= in_rf_waddr;
            wd_m[wr]   <= in_rf_wdata;
            halt_m[wr] <= in_halt;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd         <= 1'b0;
            wr         <= 1'b0;
            count      <= 2'd0;
            state      <= RUN;
            retire_cnt <= '0;
        end else begin
            rd    <= rd ^ pop;
            wr    <= wr ^ push;
            count <= count + {1'b0, push} - {1'b0, pop};
            if (pop) retire_cnt <= retire_cnt + 64'd1;
            if (state == RUN && push && in_halt) state <= DRAIN;
            else if (state == DRAIN && pop && halt_m[rd]) state <= HALTED;
        end
    end
endmodule

// File: tb/tb_ysyx_2022040010_wb_retire.sv
// tb_ysyx_2022040010_wb_retire: directed scenarios plus random traffic against a queue-based model.
module tb_ysyx_2022040010_wb_retire;
    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_rf_we = 1'b0, in_halt = 1'b0, commit_ready = 1'b0;
    logic [63:0] in_pc = '0, in_rf_wdata = '0;
    logic [4:0] in_rf_waddr = '0, q_addr = '0;
    logic in_ready, commit_valid, rf_we, q_hit, halted;
    logic [63:0] commit_pc, rf_wdata, q_data, retire_cnt;
    logic [4:0] rf_waddr;
    int n_cmp = 0, n_bad = 0;

    ysyx_2022040010_wb_retire dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr), .in_rf_wdata(in_rf_wdata), .in_halt(in_halt),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_pc(commit_pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .q_addr(q_addr), .q_hit(q_hit),
        .q_data(q_data), .retire_cnt(retire_cnt), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {logic [63:0] pc; logic we; logic [4:0] wa; logic [63:0] wd; logic h;} ent_t;
    ent_t mq[$];
    bit m_drain, m_halted, m_pushed;
    logic [63:0] m_cnt;

    function automatic bit e_ready();
        return mq.size() < 2 && !m_drain;
    endfunction
    function automatic bit e_cv();
        return mq.size() > 0 && !m_halted;
    endfunction
    function automatic bit e_rfwe();
        return e_cv() && commit_ready && mq[0].we && mq[0].wa != 0;
    endfunction
    function automatic bit e_hit();
        foreach (mq[i]) if (mq[i].we && mq[i].wa == q_addr && q_addr != 0) return 1'b1;
        return 1'b0;
    endfunction
    function automatic logic [63:0] e_qdata();
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].we && mq[i].wa == q_addr && q_addr != 0) return mq[i].wd;
        return '0;
    endfunction

    task automatic drive(input logic v, input logic [63:0] pc, input logic we, input logic [4:0] wa,
                         input logic [63:0] wd, input logic h);
        in_valid = v; in_pc = pc; in_rf_we = we; in_rf_waddr = wa; in_rf_wdata = wd; in_halt = h;
    endtask

    // Advance one edge, moving the model by the handshakes in effect before it.
    task automatic tick();
        bit pu, po;
        pu = in_valid && e_ready();
        po = e_cv() && commit_ready;
        if (po) begin
            if (mq[0].h) m_halted = 1'b1;
            m_cnt++;
            void'(mq.pop_front());
        end
        if (pu) begin
            mq.push_back('{in_pc, in_rf_we, in_rf_waddr, in_rf_wdata, in_halt});
            if (in_halt) m_drain = 1'b1;
        end
        m_pushed = pu;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        commit_ready = 1'b0;
        mq.delete();
        m_drain = 0; m_halted = 0; m_cnt = '0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        q_addr = 5'd3;
        #4;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (commit_valid !== 1'b0) begin n_bad++; $display("FAIL rst_commit_valid: got %b expected 0", commit_valid); end
        n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL rst_rf_we: got %b expected 0", rf_we); end
        n_cmp++; if (q_hit !== 1'b0) begin n_bad++; $display("FAIL rst_q_hit: got %b expected 0", q_hit); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted: got %b expected 0", halted); end
        n_cmp++; if (retire_cnt !== 64'd0) begin n_bad++; $display("FAIL rst_retire_cnt: got %h expected 0", retire_cnt); end
        tick();
    endtask

    task automatic test_stream();
        commit_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) drive(1, 64'h8000_0000 + 64'(4 * i), 1, 5'(i + 1), 64'(8'h11 * (i + 1)), 0);
            else drive(0, 0, 0, 0, 0, 0);
            #4;
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready); end
            n_cmp++; if (rf_we !== (i > 0)) begin n_bad++; $display("FAIL stream_rf_we[%0d]: got %b expected %b", i, rf_we, i > 0); end
            if (i > 0) begin
                n_cmp++; if (rf_waddr !== 5'(i)) begin n_bad++; $display("FAIL stream_waddr[%0d]: got %0d expected %0d", i, rf_waddr, i); end
                n_cmp++; if (rf_wdata !== 64'(8'h11 * i)) begin n_bad++; $display("FAIL stream_wdata[%0d]: got %h expected %h", i, rf_wdata, 8'h11 * i); end
            end
            tick();
        end
        n_cmp++; if (retire_cnt !== 64'd4) begin n_bad++; $display("FAIL stream_retire_cnt: got %0d expected 4", retire_cnt); end
    endtask

    task automatic test_backpressure();
        int k = 0;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 64'h300 + 64'(4 * i), 1, 5'(7 + i), 64'h70 + 64'(i), 0);
            #4;
            n_cmp++; if (in_ready !== (i < 2)) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b expected %b", i, in_ready, i < 2); end
            tick();
        end
        commit_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #4;
            n_cmp++; if (rf_we !== e_rfwe()) begin n_bad++; $display("FAIL bp_rf_we[%0d]: got %b expected %b", c, rf_we, e_rfwe()); end
            if (rf_we === 1'b1) begin
                n_cmp++; if (rf_waddr !== 5'(7 + k)) begin n_bad++; $display("FAIL bp_order[%0d]: got %0d expected %0d", k, rf_waddr, 7 + k); end
                k++;
            end
            tick();
            if (m_pushed) in_valid = 1'b0;
        end
        n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL bp_retired: got %0d expected 3", k); end
        n_cmp++; if (retire_cnt !== 64'd3) begin n_bad++; $display("FAIL bp_retire_cnt: got %0d expected 3", retire_cnt); end
    endtask

    task automatic test_x0_bypass();
        apply_reset();
        commit_ready = 1'b1;
        drive(1, 64'h400, 1, 0, 64'hDEAD, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        q_addr = 5'd0;
        #4;
        n_cmp++; if (commit_valid !== 1'b1) begin n_bad++; $display("FAIL x0_commit_valid: got %b expected 1", commit_valid); end
        n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL x0_rf_we: got %b expected 0", rf_we); end
        n_cmp++; if (q_hit !== 1'b0) begin n_bad++; $display("FAIL x0_q_hit: got %b expected 0", q_hit); end
        tick();
        commit_ready = 1'b0;
        drive(1, 64'h404, 1, 5, 64'hA, 0);
        tick();
        drive(1, 64'h408, 1, 5, 64'hB, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        q_addr = 5'd5;
        #4;
        n_cmp++; if (q_hit !== 1'b1) begin n_bad++; $display("FAIL byp_hit: got %b expected 1", q_hit); end
        n_cmp++; if (q_data !== 64'hB) begin n_bad++; $display("FAIL byp_data: got %h expected b", q_data); end
        #1 q_addr = 5'd6;
        #1;
        n_cmp++; if (q_hit !== 1'b0) begin n_bad++; $display("FAIL byp_miss: got %b expected 0", q_hit); end
        q_addr = 5'd5;
        commit_ready = 1'b1;
        tick();
        #4;
        n_cmp++; if (q_data !== 64'hB || q_hit !== 1'b1) begin n_bad++; $display("FAIL byp_after_pop: got %b/%h expected 1/b", q_hit, q_data); end
        tick();
    endtask

    task automatic test_halt();
        apply_reset();
        commit_ready = 1'b1;
        drive(1, 64'h100, 1, 3, 64'hA, 0);
        #4;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL halt_accept_a: got %b expected 1", in_ready); end
        tick();
        drive(1, 64'h104, 0, 0, 0, 1);
        #4;
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3) begin n_bad++; $display("FAIL halt_retire_a: got %b/%0d expected 1/3", rf_we, rf_waddr); end
        tick();
        drive(1, 64'h108, 1, 4, 64'hC, 0);
        for (int c = 0; c < 4; c++) begin
            #4;
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL halt_block_c[%0d]: got %b expected 0", c, in_ready); end
            if (c == 0) begin
                n_cmp++; if (commit_pc !== 64'h104) begin n_bad++; $display("FAIL halt_head_pc: got %h expected 104", commit_pc); end
            end
            tick();
        end
        #4;
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_halted: got %b expected 1", halted); end
        n_cmp++; if (retire_cnt !== 64'd2) begin n_bad++; $display("FAIL halt_retire_cnt: got %0d expected 2", retire_cnt); end
        n_cmp++; if (commit_valid !== 1'b0 || rf_we !== 1'b0) begin n_bad++; $display("FAIL halt_quiet: got %b/%b expected 0/0", commit_valid, rf_we); end
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(1, 64'h500, 1, 6, 64'h66, 0);
        tick();
        drive(1, 64'h504, 1, 7, 64'h77, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        commit_ready = 1'b1;
        q_addr = 5'd6;
        #2;
        n_cmp++; if (rf_we !== e_rfwe()) begin n_bad++; $display("FAIL mid_pre_rf_we: got %b expected %b", rf_we, e_rfwe()); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || commit_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_hs: got %b/%b expected 1/0", in_ready, commit_valid); end
        n_cmp++; if (rf_we !== 1'b0 || q_hit !== 1'b0) begin n_bad++; $display("FAIL mid_rst_we_hit: got %b/%b expected 0/0", rf_we, q_hit); end
        n_cmp++; if (halted !== 1'b0 || retire_cnt !== 64'd0) begin n_bad++; $display("FAIL mid_rst_cnt: got %b/%0d expected 0/0", halted, retire_cnt); end
        mq.delete();
        m_drain = 0; m_halted = 0; m_cnt = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        commit_ready = 1'b0;
        drive(1, 64'h200, 1, 2, 64'h22, 0);
        #4;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_post_ready: got %b expected 1", in_ready); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #4;
        n_cmp++; if (commit_valid !== 1'b1 || commit_pc !== 64'h200) begin n_bad++; $display("FAIL mid_post_push: got %b/%h expected 1/200", commit_valid, commit_pc); end
        tick();
    endtask

    task automatic test_wrap();
        apply_reset();
        force dut.retire_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        drive(1, 64'h600, 1, 1, 64'h1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        release dut.retire_cnt;
        #4;
        n_cmp++; if (retire_cnt !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL wrap_pre: got %h expected all ones", retire_cnt); end
        commit_ready = 1'b1;
        tick();
        #2;
        n_cmp++; if (retire_cnt !== 64'd0) begin n_bad++; $display("FAIL wrap_post: got %h expected 0", retire_cnt); end
        tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 1), {32'h8000_0000, $urandom}, $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                  {$urandom, $urandom}, $urandom_range(0, 19) == 0);
            commit_ready = $urandom_range(0, 2) != 0;
            q_addr = 5'($urandom_range(0, 7));
            #4;
            n_cmp++; if (in_ready !== e_ready()) begin n_bad++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", c, in_ready, e_ready()); end
            n_cmp++; if (commit_valid !== e_cv()) begin n_bad++; $display("FAIL rnd_commit_valid[%0d]: got %b expected %b", c, commit_valid, e_cv()); end
            n_cmp++; if (rf_we !== e_rfwe()) begin n_bad++; $display("FAIL rnd_rf_we[%0d]: got %b expected %b", c, rf_we, e_rfwe()); end
            n_cmp++; if (halted !== m_halted) begin n_bad++; $display("FAIL rnd_halted[%0d]: got %b expected %b", c, halted, m_halted); end
            n_cmp++; if (retire_cnt !== m_cnt) begin n_bad++; $display("FAIL rnd_retire_cnt[%0d]: got %0d expected %0d", c, retire_cnt, m_cnt); end
            n_cmp++; if (q_hit !== e_hit()) begin n_bad++; $display("FAIL rnd_q_hit[%0d]: got %b expected %b", c, q_hit, e_hit()); end
            if (e_hit()) begin
                n_cmp++; if (q_data !== e_qdata()) begin n_bad++; $display("FAIL rnd_q_data[%0d]: got %h expected %h", c, q_data, e_qdata()); end
            end
            if (e_cv()) begin
                n_cmp++; if (commit_pc !== mq[0].pc) begin n_bad++; $display("FAIL rnd_commit_pc[%0d]: got %h expected %h", c, commit_pc, mq[0].pc); end
            end
            if (e_rfwe()) begin
                n_cmp++; if (rf_waddr !== mq[0].wa || rf_wdata !== mq[0].wd) begin n_bad++; $display("FAIL rnd_rf_data[%0d]: got %0d/%h expected %0d/%h", c, rf_waddr, rf_wdata, mq[0].wa, mq[0].wd); end
            end
            tick();
            if (m_halted && $urandom_range(0, 3) == 0) apply_reset();
        end
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_x0_bypass();
        test_halt();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
